// File: rtl/msg_schedule_if.sv
// Valid/ready stream bundle for msg_schedule: message words in, schedule words out.
interface msg_schedule_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    // slave is the schedule block; master is the padder/round datapath around it
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/msg_schedule.sv
// SHA-2 message-schedule generator: loads W0..W15, then expands to W(ROUNDS-1).
// Optional round_idx output port enabled by defining MSG_SCHED_ROUND_IDX_EN.
module msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    msg_schedule_if.slave bus,
    output logic          busy
`ifdef MSG_SCHED_ROUND_IDX_EN
    ,
    output logic [7:0]    round_idx
`endif
);
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("msg_schedule: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 17 || ROUNDS > 255) begin : g_bad_rounds
        $error("msg_schedule: ROUNDS must be in 17..255");
    end

    localparam int S0_R1 = (WORD_W == 32) ? 7  : 1;
    localparam int S0_R2 = (WORD_W == 32) ? 18 : 8;
    localparam int S0_SH = (WORD_W == 32) ? 3  : 7;
    localparam int S1_R1 = (WORD_W == 32) ? 17 : 19;
    localparam int S1_R2 = (WORD_W == 32) ? 19 : 61;
    localparam int S1_SH = (WORD_W == 32) ? 10 : 6;
    localparam logic [7:0] LAST_T = 8'(ROUNDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    state_t            r_state;
    logic [WORD_W-1:0] r_w [16];
    logic [7:0]        r_t;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_last;
`ifdef MSG_SCHED_ROUND_IDX_EN
    logic [7:0]        r_round_idx;
`endif

    logic              w_free;
    logic              w_load_hs;
    logic              w_expand_step;
    logic              w_push;
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] w_push_data;

    // A word may be produced whenever the output slot is empty or being drained.
    assign w_free        = !r_out_valid || bus.out_ready;
    assign w_load_hs     = (r_state == ST_LOAD) && w_free && bus.in_valid;
    assign w_expand_step = (r_state == ST_EXPAND) && w_free;
    assign w_push        = w_load_hs || w_expand_step;
    assign w_new         = sig1(r_w[14]) + r_w[9] + sig0(r_w[1]) + r_w[0];
    assign w_push_data   = (r_state == ST_LOAD) ? bus.in_data : w_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_t         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
`ifdef MSG_SCHED_ROUND_IDX_EN
            r_round_idx <= '0;
`endif
            // NOTE: the 16-word window is flop-based and small, so it is reset
            // like the rest of the state; a RAM-mapped array would not be.
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_t         <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_push) begin
                for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                r_w[15]     <= w_push_data;
                r_out_data  <= w_push_data;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b0;
`ifdef MSG_SCHED_ROUND_IDX_EN
                r_round_idx <= r_t;
`endif
                r_t         <= r_t + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_t     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_hs && r_t == 8'd15) r_state <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    // Later assignment overrides the clear done by the push above.
                    if (w_expand_step && r_t == LAST_T) begin
                        r_out_last <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD) && w_free;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign busy          = (r_state != ST_IDLE);
`ifdef MSG_SCHED_ROUND_IDX_EN
    assign round_idx     = r_round_idx;
`endif

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: one 32-bit and one 64-bit instance,
// compared against a FIPS-style recurrence model computed in the bench.
module tb_msg_schedule;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    bit          wide;

    int checks   = 0;
    int failures = 0;

    msg_schedule_if #(.WORD_W(32)) if32 ();
    msg_schedule_if #(.WORD_W(64)) if64 ();

    logic busy32, busy64;
    logic start32, start64;
    assign start32 = start & ~wide;
    assign start64 = start & wide;

    assign if32.in_valid  = in_valid;
    assign if32.in_data   = in_data[31:0];
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_data   = in_data;
    assign if64.out_ready = out_ready;

`ifdef MSG_SCHED_ROUND_IDX_EN
    logic [7:0] ridx32, ridx64, o_ridx;
    assign o_ridx = wide ? ridx64 : ridx32;
`endif

    msg_schedule #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort), .bus(if32), .busy(busy32)
`ifdef MSG_SCHED_ROUND_IDX_EN
        , .round_idx(ridx32)
`endif
    );

    msg_schedule #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort), .bus(if64), .busy(busy64)
`ifdef MSG_SCHED_ROUND_IDX_EN
        , .round_idx(ridx64)
`endif
    );

    logic        o_valid, o_last, o_in_ready, o_busy;
    logic [63:0] o_data;
    assign o_valid    = wide ? if64.out_valid : if32.out_valid;
    assign o_last     = wide ? if64.out_last  : if32.out_last;
    assign o_in_ready = wide ? if64.in_ready  : if32.in_ready;
    assign o_busy     = wide ? busy64 : busy32;
    assign o_data     = wide ? if64.out_data : {32'h0, if32.out_data};

    // Reference schedule and captured DUT words
    logic [63:0] exp_w [80];
    logic [63:0] got   [80];
    int          rounds;

    logic [63:0] abc32 [16];
    logic [63:0] abc64 [16];
    logic [63:0] rmsg  [16];
    logic [63:0] rmsg2 [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit w);
        logic [127:0] d;
        if (w) begin
            d = {x, x} >> n;
            return d[63:0];
        end
        d = {64'h0, x[31:0], x[31:0]} >> n;
        return {32'h0, d[31:0]};
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input bit w);
        return w ? (rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7))
                 : (rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3));
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input bit w);
        return w ? (rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6))
                 : (rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10));
    endfunction

    task automatic build_ref(input bit w, input logic [63:0] msg [16]);
        logic [63:0] mask;
        mask   = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rounds = w ? 80 : 64;
        for (int i = 0; i < 16; i++) exp_w[i] = msg[i] & mask;
        for (int i = 16; i < rounds; i++)
            exp_w[i] = (ssig1(exp_w[i-2], w) + exp_w[i-7] + ssig0(exp_w[i-15], w) + exp_w[i-16]) & mask;
    endtask

    task automatic rand_msg(output logic [63:0] m [16]);
        for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
    endtask

    // One block: optional random stalls, a 5-cycle hold, abort, reset, or a chained start.
    task automatic run_block(input bit w, input logic [63:0] msg [16], input bit rnd,
                             input int hold_at, input int abort_at, input int rst_at,
                             input bit chain, input logic [63:0] chain_w0,
                             input bit no_start, input bit timed);
        int          k = 0;
        int          idx = 0;
        int          cyc = 0;
        int          hold_cnt = 0;
        int          last_cyc = -1;
        bit          held = 0;
        bit          chained = 0;
        bit          pend = 0;
        bit          in_hs, out_hs;
        logic [63:0] pend_data = '0;
        wide = w;
        build_ref(w, msg);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!no_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc   = 1;
            check("busy_after_start", o_busy, 1);
            check("in_ready_after_start", o_in_ready, 1);
        end
        for (int guard = 0; guard < 3000 && idx < rounds; guard++) begin
            if (chain && !chained && idx == rounds - 1) begin
                chained   = 1;
                out_ready = 1'b0;
                start     = 1'b1;
                in_valid  = 1'b1;
                in_data   = chain_w0;
                @(negedge clk);
                check("chain_in_ready", o_in_ready, 0);
                check("chain_last_pending", o_last, 1);
                @(posedge clk); #1;
                start    = 1'b0;
                in_valid = 1'b0;
                cyc++;
                check("chain_busy", o_busy, 1);
                check("chain_hold_data", o_data, exp_w[rounds-1]);
                check("chain_in_ready2", o_in_ready, 0);
                pend = 0;
                continue;
            end
            if (hold_at == idx && !held) begin
                held     = 1;
                hold_cnt = 5;
            end
            in_valid  = (k < 16) && (!rnd || $urandom_range(0, 2) != 0);
            in_data   = msg[(k < 16) ? k : 15];
            out_ready = (hold_cnt == 0) && (!rnd || $urandom_range(0, 2) != 0);
            start     = rnd && (idx + 2 < rounds) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (pend) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, pend_data);
            end
            if (hold_cnt > 0) begin
                check("hold_data", o_data, exp_w[hold_at]);
                hold_cnt--;
            end
            if (abort_at == idx && o_valid) begin
                abort = 1'b1;
                start = 1'b1;
                @(posedge clk); #1;
                abort    = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                check("abort_valid", o_valid, 0);
                check("abort_busy", o_busy, 0);
                check("abort_last", o_last, 0);
                return;
            end
            if (rst_at == idx && o_valid) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", o_valid, 0);
                check("rst_last", o_last, 0);
                check("rst_busy", o_busy, 0);
                check("rst_in_ready", o_in_ready, 0);
                check("rst_data", o_data, 0);
`ifdef MSG_SCHED_ROUND_IDX_EN
                check("rst_ridx", o_ridx, 0);
`endif
                start = 1'b1;
                @(posedge clk); #1;
                start    = 1'b0;
                in_valid = 1'b0;
                check("rst_start_ignored", o_busy, 0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("post_rst_valid", o_valid, 0);
                check("post_rst_busy", o_busy, 0);
                return;
            end
            out_hs = o_valid && out_ready;
            in_hs  = in_valid && o_in_ready;
            if (o_valid && o_last && last_cyc < 0) last_cyc = cyc;
            if (out_hs) begin
                check($sformatf("w%0d", idx), o_data, exp_w[idx]);
                check($sformatf("last%0d", idx), o_last, (idx == rounds - 1));
`ifdef MSG_SCHED_ROUND_IDX_EN
                check($sformatf("ridx%0d", idx), o_ridx, idx);
`endif
                got[idx] = o_data;
                idx++;
            end
            pend      = o_valid && !out_ready;
            pend_data = o_data;
            @(posedge clk); #1;
            cyc++;
            if (in_hs) k++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (idx < rounds) check("timeout_words", idx, rounds);
        if (timed) check("block_cycles", last_cyc, rounds + 1);
        if (!chain) check("busy_end", o_busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        wide      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            abc32[i] = '0;
            abc64[i] = '0;
        end
        abc32[0]  = 64'h6162_6380;
        abc32[15] = 64'h18;
        abc64[0]  = 64'h6162_6380_0000_0000;
        abc64[15] = 64'h18;

        // Reset state of both instances
        #1;
        check("rst32_valid", if32.out_valid, 0);
        check("rst32_last", if32.out_last, 0);
        check("rst32_ready", if32.in_ready, 0);
        check("rst32_data", if32.out_data, 0);
        check("rst32_busy", busy32, 0);
        check("rst64_valid", if64.out_valid, 0);
        check("rst64_data", if64.out_data, 0);
        check("rst64_busy", busy64, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", o_busy, 0);
        check("idle_in_ready", o_in_ready, 0);

        // SHA-256 "abc", full throughput
        run_block(0, abc32, 0, -1, -1, -1, 0, '0, 0, 1);
        check("abc32_w16", got[16], 64'h6162_6380);
        check("abc32_w17", got[17], 64'h000F_0000);
        check("abc32_w18", got[18], 64'h7DA8_6405);

        // SHA-512 "abc", full throughput
        run_block(1, abc64, 0, -1, -1, -1, 0, '0, 0, 1);
        check("abc64_w16", got[16], 64'h6162_6380_0000_0000);
        check("abc64_w17", got[17], 64'h0003_0000_0000_00C0);

        // Output hold at t=20, then random stalls and input gaps
        run_block(0, abc32, 0, 20, -1, -1, 0, '0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            rand_msg(rmsg);
            run_block(0, rmsg, 1, -1, -1, -1, 0, '0, 0, 0);
        end
        rand_msg(rmsg);
        run_block(1, rmsg, 1, -1, -1, -1, 0, '0, 0, 0);

        // Abort mid-block, then a clean "abc" block
        rand_msg(rmsg);
        run_block(0, rmsg, 0, -1, 30, -1, 0, '0, 0, 0);
        run_block(0, abc32, 0, -1, -1, -1, 0, '0, 0, 1);
        check("abort_rerun_w18", got[18], 64'h7DA8_6405);

        // Reset mid-block, then a clean block
        run_block(0, abc32, 0, -1, -1, 40, 0, '0, 0, 0);
        run_block(0, abc32, 0, -1, -1, -1, 0, '0, 0, 1);

        // Start while the final word is pending, next block chained behind it
        rand_msg(rmsg2);
        run_block(0, abc32, 0, -1, -1, -1, 1, rmsg2[0], 0, 0);
        run_block(0, rmsg2, 0, -1, -1, -1, 0, '0, 1, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
